// File: rtl/alu_pkg.sv
// Shared type definitions for the multicycle ALU.
//   alu_op_t    : 3-bit operation code (ADD, SUB, MUL, DIV, CMP; 101-111 reserved)
//   alu_state_t : control FSM state encoding (IDLE, DIV_RUN, RESULT)
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_CMP = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_DIV_RUN = 2'b01,
    ST_RESULT  = 2'b10
  } alu_state_t;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// The load cycle already computes the first quotient bit, so the
// quotient is final WIDTH-1 edges after the load edge (busy drops then).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   load                : capture dividend/divisor and start
//   dividend, divisor   : unsigned operands
//   busy                : high while quotient bits remain to be produced
//   quotient            : quotient (all ones when divisor is zero)
module alu_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic [WIDTH-1:0] quotient
);
  import alu_pkg::*;

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // One restoring step: shift the next dividend bit (MSB of quo) into the
  // partial remainder, subtract if it fits, shift the quotient bit in.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (diff[WIDTH]) begin
      div_step = {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    end else begin
      div_step = {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    end
  endfunction

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load) begin
      {rem_d, quo_d} = div_step('0, dividend, divisor);
      dvs_d          = divisor;
      cnt_d          = CW'(WIDTH - 1);
    end else if (cnt_q != '0) begin
      {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
      cnt_d          = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy     = (cnt_q != '0);
  assign quotient = quo_q;

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ADD/SUB/MUL/CMP, iterative DIV.
// Optional feature macro: MULTICYCLE_ALU_DIV_EN enables DIV (and the
// alu_divider instance); without it DIV behaves as a reserved op.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   enable, start : request accepted when start && enable && !busy
//   op            : operation code (alu_op_t)
//   rs, rt        : unsigned operands, captured on acceptance
//   result        : registered result, held between valid pulses
//   result_valid  : one-cycle pulse when result is new
//   busy          : high while an operation is in progress
//   div_by_zero   : sticky flag for the last DIV with rt == 0
module multicycle_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             div_by_zero
);
  import alu_pkg::*;

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;
  logic             accept;

`ifdef MULTICYCLE_ALU_DIV_EN
  logic             rtz_q, rtz_d;
  logic             div_load;
  logic             div_busy;
  logic [WIDTH-1:0] div_quo;

  alu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load),
    .dividend (rs),
    .divisor  (rt),
    .busy     (div_busy),
    .quotient (div_quo)
  );
`endif

  assign accept = start && enable && !busy_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    dbz_d    = dbz_q;
`ifdef MULTICYCLE_ALU_DIV_EN
    rtz_d    = rtz_q;
    div_load = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RESULT;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          case (alu_op_t'(op))
            OP_ADD: result_d = rs + rt;
            OP_SUB: result_d = rs - rt;
            OP_MUL: result_d = rs * rt;
            OP_CMP: result_d = {{(WIDTH-3){1'b0}}, rs < rt, rs == rt, rs > rt};
`ifdef MULTICYCLE_ALU_DIV_EN
            OP_DIV: begin
              // result and flag are updated together when the quotient lands
              state_d  = ST_DIV_RUN;
              valid_d  = 1'b0;
              div_load = 1'b1;
              rtz_d    = (rt == '0);
            end
`endif
            default: result_d = '0;
          endcase
        end
      end
`ifdef MULTICYCLE_ALU_DIV_EN
      ST_DIV_RUN: begin
        if (!div_busy) begin
          state_d  = ST_RESULT;
          valid_d  = 1'b1;
          result_d = rtz_q ? '1 : div_quo;
          dbz_d    = rtz_q;
        end
      end
`endif
      ST_RESULT: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      dbz_q    <= 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
      rtz_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      dbz_q    <= dbz_d;
`ifdef MULTICYCLE_ALU_DIV_EN
      rtz_q    <= rtz_d;
`endif
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
  assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=8): directed literal cases
// plus randomized traffic compared every cycle against a latency-queue model.
module tb_multicycle_alu;
  localparam int W = 8;
`ifdef MULTICYCLE_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         enable = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] rs = '0;
  logic [W-1:0] rt = '0;
  logic [W-1:0] result;
  logic         result_valid;
  logic         busy;
  logic         div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .op           (op),
    .rs           (rs),
    .rt           (rt),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic logic [W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int unsigned ia = a;
    int unsigned ib = b;
    case (o)
      3'd0: return W'((ia + ib) % 256);
      3'd1: return W'((ia + 256 - ib) % 256);
      3'd2: return W'((ia * ib) % 256);
      3'd3: begin
        if (!DIV_EN) return '0;
        if (ib == 0) return 8'hFF;
        return W'(ia / ib);
      end
      3'd4: return W'((ia < ib) * 4 + (ia == ib) * 2 + (ia > ib));
      default: return '0;
    endcase
  endfunction

  // Behavioural model: a pending result delivered after the op latency.
  logic [W-1:0] m_result = '0;
  logic         m_valid = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_dbz = 1'b0;
  int           pend = 0;
  logic [W-1:0] pend_res = '0;
  logic         pend_dbz = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_result = '0; m_valid = 1'b0; m_busy = 1'b0; m_dbz = 1'b0; pend = 0;
    end else begin
      logic acc;
      acc = start && enable && !m_busy;
      m_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          m_result = pend_res;
          m_valid  = 1'b1;
          m_dbz    = pend_dbz;
        end
      end
      if (acc) begin
        if (op == 3'd3 && DIV_EN) begin
          pend     = W;           // delivered W+1 edges after acceptance
          pend_res = ref_result(op, rs, rt);
          pend_dbz = (rt == '0);
        end else begin
          m_result = ref_result(op, rs, rt);
          m_valid  = 1'b1;
        end
      end
      m_busy = (pend > 0) || m_valid;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_result", result, m_result);
    chk("model_valid", result_valid, m_valid);
    chk("model_busy", busy, m_busy);
    chk("model_dbz", div_by_zero, m_dbz);
  end

  // Directed op with literal expectation; optional start injected mid-operation.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input int exp_lat, input bit exp_dbz,
                        input bit mid_start);
    int lat;
    bit got;
    @(posedge clk); #1;
    op = o; rs = a; rt = b; enable = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rs = W'($urandom); rt = W'($urandom);
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (result_valid) got = 1'b1;
      else begin
        chk("busy_during_op", busy, 1);
        if (mid_start && lat == 3) begin
          start = 1'b1; op = 3'd0; rs = 8'd1; rt = 8'd1;
        end else start = 1'b0;
      end
    end
    start = 1'b0;
    chk("latency", lat, exp_lat);
    chk("lit_result", result, exp_res);
    chk("lit_dbz", div_by_zero, exp_dbz);
    @(negedge clk);
    chk("valid_one_cycle", result_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    #1;
    chk("reset_result", result, 0);
    chk("reset_valid", result_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_op(3'd0, 8'd200, 8'd100, 8'd44, 1, 1'b0, 1'b0);
    run_op(3'd2, 8'd16, 8'd17, 8'd16, 1, 1'b0, 1'b0);
    run_op(3'd4, 8'd3, 8'd7, 8'b0000_0100, 1, 1'b0, 1'b0);
    run_op(3'd1, 8'd3, 8'd5, 8'd254, 1, 1'b0, 1'b0);
    run_op(3'd6, 8'd9, 8'd9, 8'd0, 1, 1'b0, 1'b0);
    if (DIV_EN) begin
      run_op(3'd3, 8'd100, 8'd7, 8'd14, 9, 1'b0, 1'b1);
      run_op(3'd3, 8'd5, 8'd0, 8'hFF, 9, 1'b1, 1'b0);
      run_op(3'd0, 8'd2, 8'd3, 8'd5, 1, 1'b1, 1'b0);
      run_op(3'd3, 8'd9, 8'd3, 8'd3, 9, 1'b0, 1'b0);
    end else begin
      run_op(3'd3, 8'd100, 8'd7, 8'd0, 1, 1'b0, 1'b0);
      run_op(3'd3, 8'd5, 8'd0, 8'd0, 1, 1'b0, 1'b0);
    end

    // start with enable low is ignored
    @(posedge clk); #1;
    enable = 1'b0; start = 1'b1; op = 3'd0; rs = 8'd1; rt = 8'd2;
    @(posedge clk); #1;
    start = 1'b0; enable = 1'b1;
    @(negedge clk);
    chk("noenable_busy", busy, 0);
    chk("noenable_valid", result_valid, 0);

    // reset in the middle of a DIV aborts it
    @(posedge clk); #1;
    op = 3'd3; rs = 8'd100; rt = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort_result", result, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_dbz", div_by_zero, 0);
    @(posedge clk); #1 reset = 1'b0;
    run_op(3'd0, 8'd1, 8'd1, 8'd2, 1, 1'b0, 1'b0);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      start  = ($urandom_range(0, 2) == 0);
      enable = ($urandom_range(0, 4) != 0);
      op     = 3'($urandom_range(0, 7));
      rs     = W'($urandom);
      rt     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 4..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  thread active; when low, start is ignored.
REQ-005 SHALL have port start  input  1  one-cycle request to begin an operation.
REQ-006 SHALL have port op  input  3  operation: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 CMP; 101-111 reserved.
REQ-007 SHALL have ports rs and rt  input  WIDTH  unsigned operands.
REQ-008 SHALL have port result  output  WIDTH  registered result.
REQ-009 SHALL have port result_valid  output  1  one-cycle pulse marking result as new.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port div_by_zero  output  1  sticky flag for the last DIV having rt == 0.

Function
REQ-012 SHALL accept a request when start && enable && !busy; operands and op are captured in that cycle.
REQ-013 SHALL implement FSM states IDLE, DIV_RUN, and RESULT.
REQ-014 SHALL go IDLE->RESULT on an accepted ADD/SUB/MUL/CMP/reserved op, so result_valid pulses on the cycle after acceptance (latency 1).
REQ-015 SHALL go IDLE->DIV_RUN on an accepted DIV, perform restoring division one quotient bit per cycle for exactly WIDTH cycles, then go to RESULT (latency WIDTH+1).
REQ-016 SHALL return from RESULT to IDLE unconditionally after one cycle; result_valid is high only in RESULT.
REQ-017 SHALL assert busy in DIV_RUN and RESULT; a start during busy is dropped without effect.
REQ-018 SHALL compute ADD, SUB and MUL modulo 2^WIDTH (low WIDTH bits kept, wrap-around silent).
REQ-019 SHALL produce, for CMP, result = {zeros, rs<rt, rs==rt, rs>rt} in bits [2:0].
REQ-020 SHALL produce, for DIV with rt == 0, result = all ones and div_by_zero = 1, with latency still WIDTH+1.
REQ-021 SHALL clear div_by_zero on the next accepted DIV with rt != 0; other ops leave it unchanged.
REQ-022 SHALL produce result = 0 for reserved op codes.
REQ-023 SHALL hold result stable between result_valid pulses.
REQ-024 SHALL ignore operand changes on rs/rt after acceptance.

Reset
REQ-025 SHALL, on reset assertion, immediately force state IDLE, result = 0, result_valid = 0, busy = 0, div_by_zero = 0, and clear divider registers.
REQ-026 SHALL abort an in-flight DIV on reset with no result_valid pulse; the first accepted start after deassertion behaves as from power-up.

Configuration
REQ-027 SHALL, with macro MULTICYCLE_ALU_DIV_EN defined, implement DIV as in REQ-015/REQ-020.
REQ-028 SHALL, without MULTICYCLE_ALU_DIV_EN, treat DIV as a reserved op (result 0, latency 1, div_by_zero held 0), and SHALL NOT instantiate the divider.

Structure
REQ-029 SHALL take op encodings (alu_op_t) and FSM state encoding (alu_state_t) from shared package alu_pkg.
REQ-030 SHALL place the iterative divider in sub-module alu_divider (load, busy-count, quotient out), instantiated only under MULTICYCLE_ALU_DIV_EN.

Verification (WIDTH=8)
REQ-031 SHALL cover: ADD rs=200 rt=100 -> result 44, result_valid pulse 1 cycle after accept.
REQ-032 SHALL cover: MUL rs=16 rt=17 -> result 16; CMP rs=3 rt=7 -> result 8'b0000_0100.
REQ-033 SHALL cover: DIV rs=100 rt=7 -> result 14, valid exactly 9 cycles after accept, busy high throughout; start issued mid-DIV is dropped.
REQ-034 SHALL cover: DIV rs=5 rt=0 -> result 8'hFF, div_by_zero=1; then DIV 9/3 -> result 3, div_by_zero=0.
REQ-035 SHALL cover: reset asserted at DIV cycle 4 -> outputs 0 immediately, no valid pulse; ADD 1+1 afterwards -> result 2.
REQ-036 SHALL cover: start with enable=0 -> no busy, no result_valid; build without MULTICYCLE_ALU_DIV_EN, DIV 100/7 -> result 0 at latency 1.
